// File: rtl/afifo_pkg.sv
// Shared types for the afifo read-side burst reader.
// Burst state encoding and beat counter sizing.
package afifo_pkg;

    typedef enum logic {
        IDLE,
        BURST
    } burst_state_e;

    function automatic int beat_cnt_w(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/afifo_rdr_buf.sv
// Two-entry FIFO skid buffer between the afifo pop and the output stream.
// Caller never pushes when full nor pops when empty.
module afifo_rdr_buf #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         wr_q, wr_d;
    logic         rd_q, rd_d;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q] = push_data;
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/afifo_rdr.sv
// Afifo read-side drainer producing a valid/ready beat stream.
// Define AFIFO_RDR_BURST_EN for burst-gated popping with m_last tagging.
module afifo_rdr
    import afifo_pkg::*;
#(
    parameter int AW        = 4,
    parameter int DW        = 8,
    parameter int BURST_LEN = 8
) (
    input  logic          rclk,
    input  logic          rreset_n,
    input  logic          rempty,
    input  logic [AW:0]   rcnt,
    input  logic [DW-1:0] q,
    output logic          re,
    input  logic          flush,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last
);

    logic        pop_allowed;
    logic        last_tag;
    logic        pop;
    logic [DW:0] head;
    logic [1:0]  count;

    // Buffer occupancy gates popping, so m_ready never reaches re.
    assign re      = rreset_n && pop_allowed && !rempty && (count < 2'd2);
    assign m_valid = rreset_n && (count != 2'd0);
    assign pop     = m_valid && m_ready;
    assign m_data  = head[DW-1:0];

    afifo_rdr_buf #(
        .W(DW + 1)
    ) u_buf (
        .clk      (rclk),
        .rst_n    (rreset_n),
        .push     (re),
        .push_data({last_tag, q}),
        .pop      (pop),
        .head     (head),
        .count    (count)
    );

`ifdef AFIFO_RDR_BURST_EN
    localparam int CW = beat_cnt_w(BURST_LEN);

    burst_state_e  state_q, state_d;
    logic [CW-1:0] len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        last_tag = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rcnt >= (AW+1)'(BURST_LEN)) begin
                    state_d = BURST;
                    len_d   = CW'(BURST_LEN);
                    cnt_d   = '0;
                end else if (flush && (rcnt != '0)) begin
                    state_d = BURST;
                    len_d   = CW'(rcnt);
                    cnt_d   = '0;
                end
            end
            BURST: begin
                last_tag = ((cnt_q + CW'(1)) == len_q);
                if (re) begin
                    cnt_d = cnt_q + CW'(1);
                    if (last_tag) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (!rreset_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pop_allowed = (state_q == BURST);
    assign m_last      = m_valid && head[DW];
`else
    logic unused_cfg;

    assign pop_allowed = 1'b1;
    assign last_tag    = 1'b0;
    assign m_last      = 1'b0;
    assign unused_cfg  = ^{flush, rcnt, head[DW], 32'(BURST_LEN)};
`endif

endmodule

// File: tb/tb_afifo_rdr.sv
// Self-checking bench for afifo_rdr: vector table, directed sequences,
// and a randomized afifo/sink against a queue-based occupancy model.
module tb_afifo_rdr;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rreset_n;
    logic          rempty;
    logic [AW:0]   rcnt;
    logic [DW-1:0] q;
    logic          re;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    afifo_rdr #(
        .AW       (AW),
        .DW       (DW),
        .BURST_LEN(BL)
    ) dut (
        .rclk    (clk),
        .rreset_n(rreset_n),
        .rempty  (rempty),
        .rcnt    (rcnt),
        .q       (q),
        .re      (re),
        .flush   (flush),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] d;
    } beat_t;

    typedef struct {
        logic          rst;
        logic          emp;
        logic          rdy;
        logic [DW-1:0] d;
        logic          e_re;
        logic          e_val;
        logic [DW-1:0] e_data;
    } vec_t;

    logic [DW-1:0] afq[$];
    beat_t         sbq[$];
    int            occ;
    int            rem;
    int            tests;
    int            fails;
    int            dut_beats;
    int            dut_last_idx;
    int            dut_pops;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: drive afifo view from afq, check outputs, advance model.
    task automatic step(input logic rst, input logic fl, input logic rdy);
        logic  pa;
        logic  exp_re;
        logic  exp_val;
        int    n;
        beat_t b;
        n        = afq.size();
        rreset_n = rst;
        flush    = fl;
        m_ready  = rdy;
        rempty   = (n == 0);
        rcnt     = (AW+1)'(n);
        q        = (n == 0) ? '0 : afq[0];
        #1;
`ifdef AFIFO_RDR_BURST_EN
        pa = (rem > 0);
`else
        pa = 1'b1;
`endif
        exp_re  = rst && pa && (n != 0) && (occ < 2);
        exp_val = rst && (occ != 0);
        chk("re", 32'(re), 32'(exp_re));
        chk("m_valid", 32'(m_valid), 32'(exp_val));
        if (exp_val) begin
            chk("m_data", 32'(m_data), 32'(sbq[0].d));
            chk("m_last", 32'(m_last), 32'(sbq[0].last));
        end else begin
            chk("m_last_idle", 32'(m_last), 32'd0);
        end
        if (rst && m_valid && m_ready) begin
            dut_beats++;
            if (m_last) dut_last_idx = dut_beats;
        end
        if (re) dut_pops++;
        if (!rst) begin
            occ = 0;
            rem = 0;
            sbq.delete();
        end else begin
            if (exp_val && rdy) begin
                void'(sbq.pop_front());
                occ--;
            end
            if (exp_re) begin
                b.d    = afq.pop_front();
                b.last = 1'b0;
`ifdef AFIFO_RDR_BURST_EN
                b.last = (rem == 1);
                rem--;
`endif
                sbq.push_back(b);
                occ++;
            end
`ifdef AFIFO_RDR_BURST_EN
            else if (rem == 0) begin
                if (n >= BL) rem = BL;
                else if (fl && n != 0) rem = n;
            end
`endif
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_counts();
        dut_beats    = 0;
        dut_last_idx = 0;
        dut_pops     = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (afq.size() != 0 || occ != 0); i++)
            step(1'b1, 1'b1, 1'b1);
        chk("drained", 32'(afq.size() + occ), 32'd0);
    endtask

    vec_t tbl[9];

    initial begin
        tests = 0;
        fails = 0;
        occ   = 0;
        rem   = 0;
        clear_counts();
        flush = 1'b0;

        // rst emp rdy d | re val data
        tbl[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 8'h22};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h44, 1'b0, 1'b1, 8'h22};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 8'h22};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1, 8'h33};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 8'h66};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 8'h88, 1'b0, 1'b0, 8'h00};

        // Reset with data waiting holds everything low.
        rreset_n = 1'b0;
        rempty   = 1'b0;
        rcnt     = 5'd4;
        q        = 8'hA5;
        m_ready  = 1'b1;
        #1;
        chk("rst_re", 32'(re), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_re_edge", 32'(re), 32'd0);
        chk("rst_m_valid_edge", 32'(m_valid), 32'd0);
        @(negedge clk);

`ifndef AFIFO_RDR_BURST_EN
        for (int i = 0; i < 9; i++) begin
            rreset_n = tbl[i].rst;
            rempty   = tbl[i].emp;
            rcnt     = tbl[i].emp ? 5'd0 : 5'd1;
            q        = tbl[i].d;
            m_ready  = tbl[i].rdy;
            #1;
            chk($sformatf("vec%0d_re", i), 32'(re), 32'(tbl[i].e_re));
            chk($sformatf("vec%0d_val", i), 32'(m_valid), 32'(tbl[i].e_val));
            if (tbl[i].e_val)
                chk($sformatf("vec%0d_data", i), 32'(m_data),
                    32'(tbl[i].e_data));
            chk($sformatf("vec%0d_last", i), 32'(m_last), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end

        // Streaming 16 words with the sink always ready.
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) afq.push_back(DW'(i));
        clear_counts();
        step(1'b1, 1'b0, 1'b1);
        chk("latency_first", 32'(dut_beats), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        chk("latency_second", 32'(dut_beats), 32'd1);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b1);
        chk("stream_beats", 32'(dut_beats), 32'd16);
        chk("stream_pops", 32'(dut_pops), 32'd16);

        // Backpressure mid-stream.
        for (int i = 0; i < 16; i++) afq.push_back(DW'(8'hC0 + i));
        clear_counts();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0);
        end
        chk("bp_occ_full_re", 32'(re), 32'd0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1);
        chk("bp_beats", 32'(dut_beats), 32'd16);
        chk("bp_pops", 32'(dut_pops), 32'd16);
`else
        // Full burst with the fill count rising 0..10.
        step(1'b0, 1'b0, 1'b1);
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            afq.push_back(DW'(i));
            step(1'b1, 1'b0, 1'b1);
        end
        for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b1);
        chk("burst_beats", 32'(dut_beats), 32'd8);
        chk("burst_last_at", 32'(dut_last_idx), 32'd8);
        chk("burst_pops", 32'(dut_pops), 32'd8);

        // Flush of a 3-word partial burst.
        afq.push_back(8'hF0);
        clear_counts();
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b1);
        chk("flush_beats", 32'(dut_beats), 32'd3);
        chk("flush_last_at", 32'(dut_last_idx), 32'd3);
        chk("flush_pops", 32'(dut_pops), 32'd3);

        // Flush with nothing waiting does nothing.
        clear_counts();
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
        chk("flush_empty_pops", 32'(dut_pops), 32'd0);
`endif

        // Reset after beat 4 of a 10-word backlog.
        drain();
        for (int i = 0; i < 10; i++) afq.push_back(DW'(8'h50 + i));
        clear_counts();
        for (int i = 0; i < 40 && dut_beats < 4; i++) step(1'b1, 1'b0, 1'b1);
        chk("mid_reach4", 32'(dut_beats), 32'd4);
        step(1'b0, 1'b0, 1'b1);
        rreset_n = 1'b1;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_m_last", 32'(m_last), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        drain();

        // Random afifo fill and sink stalls.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0 && afq.size() < 16)
                afq.push_back(DW'($urandom));
            step(1'b1, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
